uart_rx_os: RTL

//   UART receiver driven by the bclkgen oversampling clock. Samples the serial rxd line at

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_os_if.sv | 23 ++
 rtl/uart_rx_sync.sv | 37 +++
 rtl/uart_rx_os.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: state encoding,
// default sizing and the mid-bit sample position.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int SCALE_DEF     = 16;
  localparam int DATA_BITS_DEF = 8;

  // First of the three vote samples; the other two follow on consecutive ticks.
  function automatic int mid_of(input int scale);
    return scale / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Receive-side byte handshake: one-entry holding register with status flags.
interface uart_rx_os_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, break_det,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, break_det,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Front end of the receiver: two-flop synchronizer on rxd with falling-edge
// detect, and conversion of bclk edges (either direction) into one-clock ticks.
module uart_rx_sync (
  input  logic clk,
  input  logic rstn,
  input  logic rxd,
  input  logic bclk,
  output logic rxd_s,
  output logic rxd_fall,
  output logic tick
);

  logic rxd_p0;
  logic rxd_p1;
  logic rxd_prev;
  logic bclk_prev;

  // Idle line is high, so the synchronizer powers up as if the line were idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxd_p0    <= 1'b1;
      rxd_p1    <= 1'b1;
      rxd_prev  <= 1'b1;
      bclk_prev <= 1'b0;
    end else begin
      rxd_p0    <= rxd;
      rxd_p1    <= rxd_p0;
      rxd_prev  <= rxd_p1;
      bclk_prev <= bclk;
    end
  end

  assign rxd_s    = rxd_p1;
  assign rxd_fall = rxd_prev & ~rxd_p1;
  assign tick     = bclk ^ bclk_prev;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: frames start/data/parity/stop from a 2-of-3
// mid-bit vote and hands each byte over through a one-entry valid/ready register.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int SCALE     = SCALE_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         bclk,
  input  logic         BR_config_error,
  input  logic         rx_en,
  input  logic         parity_en,
  input  logic         parity_odd,
  input  logic         rxd,
  uart_rx_os_if.master rx,
  output logic         overrun_err,
  output logic         rx_busy
);

  localparam int CNT_W = $clog2(SCALE);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int MID   = mid_of(SCALE);

  localparam logic [CNT_W-1:0] MID_C  = CNT_W'(MID);
  localparam logic [CNT_W-1:0] MID1_C = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] DEC_C  = CNT_W'(MID + 2);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(SCALE - 1);
  localparam logic [BIT_W-1:0] LBIT_C = BIT_W'(DATA_BITS - 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic rxd_s;
  logic rxd_fall;
  logic tick;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rstn     (rstn),
    .rxd      (rxd),
    .bclk     (bclk),
    .rxd_s    (rxd_s),
    .rxd_fall (rxd_fall),
    .tick     (tick)
  );

  rx_state_e        state_q;
  rx_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [BIT_W-1:0] bit_idx_q;
  logic             v0_q;
  logic             v1_q;

  logic active;
  logic at_dec;
  logic at_wrap;
  logic last_bit;
  logic vote;

  assign active   = rx_en & ~BR_config_error;
  assign at_dec   = tick & (cnt_q == DEC_C);
  assign at_wrap  = tick & (cnt_q == LAST_C);
  assign last_bit = (bit_idx_q == LBIT_C);
  assign vote     = maj3(v0_q, v1_q, rxd_s);

  // Strobes decoded from the current state
  logic busy_c;
  logic frame_start;
  logic shift_en;
  logic par_chk;
  logic stop_dec;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (rxd_fall) state_d = ST_START;
      ST_START: begin
        if (at_dec && vote) state_d = ST_IDLE;
        else if (at_wrap)   state_d = ST_DATA;
      end
      ST_DATA:   if (at_wrap && last_bit) state_d = parity_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (at_wrap) state_d = ST_STOP;
      ST_STOP:   if (at_dec) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // Disabling drops any partial frame without touching the holding register.
    if (!active) state_d = ST_IDLE;
  end

  always_comb begin
    busy_c      = 1'b1;
    frame_start = 1'b0;
    shift_en    = 1'b0;
    par_chk     = 1'b0;
    stop_dec    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy_c      = 1'b0;
        frame_start = active & rxd_fall;
      end
      ST_DATA:   shift_en = active & at_dec;
      ST_PARITY: par_chk  = active & at_dec;
      ST_STOP:   stop_dec = active & at_dec;
      default:   busy_c   = 1'b1;
    endcase
  end

  assign rx_busy = busy_c;

  // Bit timing: counter and bit index held at zero whenever idle or disabled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      bit_idx_q <= '0;
      v0_q      <= 1'b1;
      v1_q      <= 1'b1;
    end else begin
      if (!active || state_q == ST_IDLE) begin
        cnt_q     <= '0;
        bit_idx_q <= '0;
      end else if (tick) begin
        cnt_q <= at_wrap ? '0 : cnt_q + 1'b1;
        if (at_wrap && state_q == ST_DATA) bit_idx_q <= bit_idx_q + 1'b1;
      end
      if (tick && cnt_q == MID_C)  v0_q <= rxd_s;
      if (tick && cnt_q == MID1_C) v1_q <= rxd_s;
    end
  end

  // Stage p0: frame assembly
  logic [DATA_BITS-1:0] shreg_p0;
  logic                 par_bit_p0;
  logic                 perr_p0;
  logic                 perr_n;
  logic                 ferr_n;
  logic                 brk_n;

  always_ff @(posedge clk) begin
    if (shift_en) shreg_p0   <= {vote, shreg_p0[DATA_BITS-1:1]};
    if (par_chk)  par_bit_p0 <= vote;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            perr_p0 <= 1'b0;
    else if (frame_start) perr_p0 <= 1'b0;
    else if (par_chk)     perr_p0 <= (vote != (^shreg_p0 ^ parity_odd));
  end

  assign perr_n = perr_p0;
  assign ferr_n = ~vote;
  assign brk_n  = ~vote & (shreg_p0 == '0) & (~parity_en | ~par_bit_p0);

  // Stage p1: holding register and handshake
  logic [DATA_BITS-1:0] data_p1;
  logic                 vld_p1;
  logic                 perr_p1;
  logic                 ferr_p1;
  logic                 brk_p1;
  logic                 pop;

  assign pop = vld_p1 & rx.rx_ready;

  // A pop in the same cycle as a stop decision frees the slot for the new byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_p1     <= '0;
      vld_p1      <= 1'b0;
      perr_p1     <= 1'b0;
      ferr_p1     <= 1'b0;
      brk_p1      <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (stop_dec && (!vld_p1 || pop)) begin
        data_p1 <= shreg_p0;
        vld_p1  <= 1'b1;
        perr_p1 <= perr_n;
        ferr_p1 <= ferr_n;
        brk_p1  <= brk_n;
      end else begin
        if (stop_dec) overrun_err <= 1'b1;
        if (pop) begin
          vld_p1  <= 1'b0;
          perr_p1 <= 1'b0;
          ferr_p1 <= 1'b0;
          brk_p1  <= 1'b0;
        end
      end
    end
  end

  assign rx.rx_data    = data_p1;
  assign rx.rx_valid   = vld_p1;
  assign rx.parity_err = perr_p1;
  assign rx.frame_err  = ferr_p1;
  assign rx.break_det  = brk_p1;

endmodule
